// File: rtl/rs_alu_if.sv
// Bundle of control, dispatch, CDB-snoop and ALU-issue signals for the ALU
// reservation station.
interface rs_alu_if #(
    parameter int ROB_W = 4
);
    logic             rdy;
    logic             clear_in;

    logic             issue_flag_in;
    logic [5:0]       issue_op_in;
    logic [31:0]      issue_Vj_in;
    logic [31:0]      issue_Vk_in;
    logic             issue_Qj_busy_in;
    logic             issue_Qk_busy_in;
    logic [ROB_W-1:0] issue_Qj_in;
    logic [ROB_W-1:0] issue_Qk_in;
    logic [ROB_W-1:0] issue_idx_in_ROB_in;

    logic             alu_cdb_flag_in;
    logic [ROB_W-1:0] alu_cdb_idx_in;
    logic [31:0]      alu_cdb_val_in;
    logic             lsb_cdb_flag_in;
    logic [ROB_W-1:0] lsb_cdb_idx_in;
    logic [31:0]      lsb_cdb_val_in;

    logic             full_out;
    logic             alu_flag_out;
    logic [5:0]       alu_op_out;
    logic [31:0]      alu_val1_out;
    logic [31:0]      alu_val2_out;
    logic [ROB_W-1:0] alu_idx_in_ROB_out;

    modport master (
        output rdy, clear_in,
        output issue_flag_in, issue_op_in, issue_Vj_in, issue_Vk_in,
        output issue_Qj_busy_in, issue_Qk_busy_in, issue_Qj_in, issue_Qk_in,
        output issue_idx_in_ROB_in,
        output alu_cdb_flag_in, alu_cdb_idx_in, alu_cdb_val_in,
        output lsb_cdb_flag_in, lsb_cdb_idx_in, lsb_cdb_val_in,
        input  full_out, alu_flag_out, alu_op_out, alu_val1_out, alu_val2_out,
        input  alu_idx_in_ROB_out
    );

    modport slave (
        input  rdy, clear_in,
        input  issue_flag_in, issue_op_in, issue_Vj_in, issue_Vk_in,
        input  issue_Qj_busy_in, issue_Qk_busy_in, issue_Qj_in, issue_Qk_in,
        input  issue_idx_in_ROB_in,
        input  alu_cdb_flag_in, alu_cdb_idx_in, alu_cdb_val_in,
        input  lsb_cdb_flag_in, lsb_cdb_idx_in, lsb_cdb_val_in,
        output full_out, alu_flag_out, alu_op_out, alu_val1_out, alu_val2_out,
        output alu_idx_in_ROB_out
    );
endinterface

// File: rtl/rs_alu.sv
// Reservation station for the integer ALU: buffers dispatched micro-ops,
// snoops both CDBs for operands and issues the lowest-index ready entry.
module rs_alu #(
    parameter int RS_SIZE = 8,
    parameter int ROB_W   = 4
) (
    input  logic    clk,
    input  logic    rst,
    rs_alu_if.slave bus
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0] r_busy;
    logic [RS_SIZE-1:0] r_qjBusy;
    logic [RS_SIZE-1:0] r_qkBusy;
    logic [5:0]         r_op  [RS_SIZE];
    logic [31:0]        r_vj  [RS_SIZE];
    logic [31:0]        r_vk  [RS_SIZE];
    logic [ROB_W-1:0]   r_qj  [RS_SIZE];
    logic [ROB_W-1:0]   r_qk  [RS_SIZE];
    logic [ROB_W-1:0]   r_rob [RS_SIZE];

    logic               r_aluFlag;
    logic [5:0]         r_aluOp;
    logic [31:0]        r_aluVal1;
    logic [31:0]        r_aluVal2;
    logic [ROB_W-1:0]   r_aluIdx;

    logic               w_selValid;
    logic [IDX_W-1:0]   w_selIdx;
    logic [IDX_W-1:0]   w_freeIdx;
    logic               w_insert;
    logic               w_insQjBusy;
    logic               w_insQkBusy;
    logic [31:0]        w_insVj;
    logic [31:0]        w_insVk;

    // Descending scan so the lowest index wins for both select and free slot.
    always_comb begin
        w_selValid = 1'b0;
        w_selIdx   = '0;
        w_freeIdx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (r_busy[i] && !r_qjBusy[i] && !r_qkBusy[i]) begin
                w_selValid = 1'b1;
                w_selIdx   = IDX_W'(i);
            end
            if (!r_busy[i]) begin
                w_freeIdx = IDX_W'(i);
            end
        end
    end

    assign bus.full_out = &r_busy;
    assign w_insert     = bus.issue_flag_in && !bus.full_out;

    // Operands whose producer broadcasts on the dispatch edge are captured directly.
    always_comb begin
        w_insQjBusy = bus.issue_Qj_busy_in;
        w_insVj     = bus.issue_Vj_in;
        w_insQkBusy = bus.issue_Qk_busy_in;
        w_insVk     = bus.issue_Vk_in;
        if (bus.issue_Qj_busy_in) begin
            if (bus.alu_cdb_flag_in && bus.alu_cdb_idx_in == bus.issue_Qj_in) begin
                w_insQjBusy = 1'b0;
                w_insVj     = bus.alu_cdb_val_in;
            end else if (bus.lsb_cdb_flag_in && bus.lsb_cdb_idx_in == bus.issue_Qj_in) begin
                w_insQjBusy = 1'b0;
                w_insVj     = bus.lsb_cdb_val_in;
            end
        end
        if (bus.issue_Qk_busy_in) begin
            if (bus.alu_cdb_flag_in && bus.alu_cdb_idx_in == bus.issue_Qk_in) begin
                w_insQkBusy = 1'b0;
                w_insVk     = bus.alu_cdb_val_in;
            end else if (bus.lsb_cdb_flag_in && bus.lsb_cdb_idx_in == bus.issue_Qk_in) begin
                w_insQkBusy = 1'b0;
                w_insVk     = bus.lsb_cdb_val_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy    <= '0;
            r_qjBusy  <= '0;
            r_qkBusy  <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                r_op[i]  <= '0;
                r_vj[i]  <= '0;
                r_vk[i]  <= '0;
                r_qj[i]  <= '0;
                r_qk[i]  <= '0;
                r_rob[i] <= '0;
            end
            r_aluFlag <= 1'b0;
            r_aluOp   <= '0;
            r_aluVal1 <= '0;
            r_aluVal2 <= '0;
            r_aluIdx  <= '0;
        end else if (!bus.rdy) begin
            r_aluFlag <= 1'b0;
        end else if (bus.clear_in) begin
            r_busy    <= '0;
            r_aluFlag <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i] && r_qjBusy[i]) begin
                    if (bus.alu_cdb_flag_in && bus.alu_cdb_idx_in == r_qj[i]) begin
                        r_vj[i]     <= bus.alu_cdb_val_in;
                        r_qjBusy[i] <= 1'b0;
                    end else if (bus.lsb_cdb_flag_in && bus.lsb_cdb_idx_in == r_qj[i]) begin
                        r_vj[i]     <= bus.lsb_cdb_val_in;
                        r_qjBusy[i] <= 1'b0;
                    end
                end
                if (r_busy[i] && r_qkBusy[i]) begin
                    if (bus.alu_cdb_flag_in && bus.alu_cdb_idx_in == r_qk[i]) begin
                        r_vk[i]     <= bus.alu_cdb_val_in;
                        r_qkBusy[i] <= 1'b0;
                    end else if (bus.lsb_cdb_flag_in && bus.lsb_cdb_idx_in == r_qk[i]) begin
                        r_vk[i]     <= bus.lsb_cdb_val_in;
                        r_qkBusy[i] <= 1'b0;
                    end
                end
            end

            r_aluFlag <= w_selValid;
            if (w_selValid) begin
                r_busy[w_selIdx] <= 1'b0;
                r_aluOp          <= r_op[w_selIdx];
                r_aluVal1        <= r_vj[w_selIdx];
                r_aluVal2        <= r_vk[w_selIdx];
                r_aluIdx         <= r_rob[w_selIdx];
            end

            // The free slot is never the selected one, so both writes can coexist.
            if (w_insert) begin
                r_busy[w_freeIdx]   <= 1'b1;
                r_op[w_freeIdx]     <= bus.issue_op_in;
                r_vj[w_freeIdx]     <= w_insVj;
                r_vk[w_freeIdx]     <= w_insVk;
                r_qjBusy[w_freeIdx] <= w_insQjBusy;
                r_qkBusy[w_freeIdx] <= w_insQkBusy;
                r_qj[w_freeIdx]     <= bus.issue_Qj_in;
                r_qk[w_freeIdx]     <= bus.issue_Qk_in;
                r_rob[w_freeIdx]    <= bus.issue_idx_in_ROB_in;
            end
        end
    end

    assign bus.alu_flag_out       = r_aluFlag;
    assign bus.alu_op_out         = r_aluOp;
    assign bus.alu_val1_out       = r_aluVal1;
    assign bus.alu_val2_out       = r_aluVal2;
    assign bus.alu_idx_in_ROB_out = r_aluIdx;
endmodule

// File: tb/tb_rs_alu.sv
// Bench for rs_alu: directed scenarios plus random traffic, all compared
// against a slot-level behavioural model of the reservation station.
module tb_rs_alu;
    localparam int RS = 8;
    localparam logic [5:0] OP_ADD = 6'd1;
    localparam logic [5:0] OP_SUB = 6'd2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rs_alu_if #(.ROB_W(4)) bus();

    rs_alu #(.RS_SIZE(RS), .ROB_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        busy;
        logic [5:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic        qjb;
        logic        qkb;
        logic [3:0]  qj;
        logic [3:0]  qk;
        logic [3:0]  rob;
    } ent_t;

    ent_t        m [RS];
    logic        mFlag;
    logic [5:0]  mOp;
    logic [31:0] mV1;
    logic [31:0] mV2;
    logic [3:0]  mIdx;

    function automatic logic mFull();
        for (int i = 0; i < RS; i++) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
        mFlag = 1'b0; mOp = '0; mV1 = '0; mV2 = '0; mIdx = '0;
    endfunction

    // Returns {still_waiting, value} after looking at this cycle's broadcasts.
    function automatic logic [32:0] snoop(logic b, logic [3:0] q, logic [31:0] v);
        if (b && bus.alu_cdb_flag_in && bus.alu_cdb_idx_in == q) return {1'b0, bus.alu_cdb_val_in};
        if (b && bus.lsb_cdb_flag_in && bus.lsb_cdb_idx_in == q) return {1'b0, bus.lsb_cdb_val_in};
        return {b, v};
    endfunction

    function automatic void modelStep();
        int sel = -1;
        int fr  = -1;
        if (!bus.rdy) begin
            mFlag = 1'b0;
            return;
        end
        if (bus.clear_in) begin
            for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
            mFlag = 1'b0;
            return;
        end
        for (int i = 0; i < RS; i++) begin
            if (sel < 0 && m[i].busy && !m[i].qjb && !m[i].qkb) sel = i;
            if (fr < 0 && !m[i].busy) fr = i;
        end
        for (int i = 0; i < RS; i++) begin
            if (m[i].busy) begin
                {m[i].qjb, m[i].vj} = snoop(m[i].qjb, m[i].qj, m[i].vj);
                {m[i].qkb, m[i].vk} = snoop(m[i].qkb, m[i].qk, m[i].vk);
            end
        end
        mFlag = (sel >= 0);
        if (sel >= 0) begin
            mOp = m[sel].op; mV1 = m[sel].vj; mV2 = m[sel].vk; mIdx = m[sel].rob;
            m[sel].busy = 1'b0;
        end
        if (bus.issue_flag_in && fr >= 0) begin
            m[fr].busy = 1'b1;
            m[fr].op   = bus.issue_op_in;
            m[fr].qj   = bus.issue_Qj_in;
            m[fr].qk   = bus.issue_Qk_in;
            m[fr].rob  = bus.issue_idx_in_ROB_in;
            {m[fr].qjb, m[fr].vj} = snoop(bus.issue_Qj_busy_in, bus.issue_Qj_in, bus.issue_Vj_in);
            {m[fr].qkb, m[fr].vk} = snoop(bus.issue_Qk_busy_in, bus.issue_Qk_in, bus.issue_Vk_in);
        end
    endfunction

    function automatic logic [75:0] dutVec();
        return {bus.full_out, bus.alu_flag_out, bus.alu_op_out, bus.alu_val1_out,
                bus.alu_val2_out, bus.alu_idx_in_ROB_out};
    endfunction

    function automatic logic [75:0] expVec();
        return {mFull(), mFlag, mOp, mV1, mV2, mIdx};
    endfunction

    task automatic idle();
        bus.rdy = 1'b1; bus.clear_in = 1'b0;
        bus.issue_flag_in = 1'b0; bus.issue_op_in = '0;
        bus.issue_Vj_in = '0; bus.issue_Vk_in = '0;
        bus.issue_Qj_busy_in = 1'b0; bus.issue_Qk_busy_in = 1'b0;
        bus.issue_Qj_in = '0; bus.issue_Qk_in = '0; bus.issue_idx_in_ROB_in = '0;
        bus.alu_cdb_flag_in = 1'b0; bus.alu_cdb_idx_in = '0; bus.alu_cdb_val_in = '0;
        bus.lsb_cdb_flag_in = 1'b0; bus.lsb_cdb_idx_in = '0; bus.lsb_cdb_val_in = '0;
    endtask

    task automatic dispatch(logic [5:0] op, logic [31:0] vj, logic [31:0] vk, logic qjb,
                            logic [3:0] qj, logic qkb, logic [3:0] qk, logic [3:0] rob);
        bus.issue_flag_in = 1'b1; bus.issue_op_in = op;
        bus.issue_Vj_in = vj; bus.issue_Vk_in = vk;
        bus.issue_Qj_busy_in = qjb; bus.issue_Qj_in = qj;
        bus.issue_Qk_busy_in = qkb; bus.issue_Qk_in = qk;
        bus.issue_idx_in_ROB_in = rob;
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        modelReset();
        @(posedge clk); #1;
        total++;
        if (dutVec() !== 76'd0) begin
            bad++; $display("[TB] FAIL reset_power got=%h exp=0", dutVec());
        end
        @(negedge clk) rst = 1'b0;
        dispatch(OP_ADD, 32'd11, 32'd22, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            dispatch(OP_SUB, 32'(i), 32'd1, 1'b1, 4'd14, 1'b0, 4'd0, 4'(i + 4));
            tick();
        end
        idle();
        total++;
        if (dutVec() !== expVec()) begin
            bad++; $display("[TB] FAIL reset_preload got=%h exp=%h", dutVec(), expVec());
        end
        #2 rst = 1'b1;
        modelReset();
        #1;
        total++;
        if (dutVec() !== 76'd0) begin
            bad++; $display("[TB] FAIL reset_async got=%h exp=0", dutVec());
        end
        @(negedge clk) rst = 1'b0;
        bus.alu_cdb_flag_in = 1'b1; bus.alu_cdb_idx_in = 4'd14; bus.alu_cdb_val_in = 32'h55;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.alu_flag_out !== 1'b0 || bus.full_out !== 1'b0) begin
                bad++; $display("[TB] FAIL reset_noissue got=%b%b exp=00", bus.alu_flag_out, bus.full_out);
            end
        end
    endtask

    task automatic test_basic();
        dispatch(OP_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
        tick();
        idle();
        total++;
        if (bus.alu_flag_out !== 1'b0) begin
            bad++; $display("[TB] FAIL basic_insert_edge got=%b exp=0", bus.alu_flag_out);
        end
        tick();
        total++;
        if ({bus.alu_flag_out, bus.alu_op_out, bus.alu_val1_out, bus.alu_val2_out, bus.alu_idx_in_ROB_out}
            !== {1'b1, OP_ADD, 32'd5, 32'd7, 4'd3}) begin
            bad++; $display("[TB] FAIL basic_issue got=%h exp=%h", dutVec(), expVec());
        end
        tick();
        total++;
        if (dutVec() !== expVec() || bus.alu_flag_out !== 1'b0) begin
            bad++; $display("[TB] FAIL basic_after got=%h exp=%h", dutVec(), expVec());
        end
    endtask

    task automatic test_wakeup();
        dispatch(OP_SUB, 32'd0, 32'd3, 1'b1, 4'd2, 1'b0, 4'd0, 4'd4);
        tick();
        idle();
        tick();
        bus.alu_cdb_flag_in = 1'b1; bus.alu_cdb_idx_in = 4'd2; bus.alu_cdb_val_in = 32'h10;
        tick();
        idle();
        total++;
        if (bus.alu_flag_out !== 1'b0) begin
            bad++; $display("[TB] FAIL wake_cdb_edge got=%b exp=0", bus.alu_flag_out);
        end
        tick();
        total++;
        if ({bus.alu_flag_out, bus.alu_op_out, bus.alu_val1_out, bus.alu_val2_out, bus.alu_idx_in_ROB_out}
            !== {1'b1, OP_SUB, 32'h10, 32'd3, 4'd4}) begin
            bad++; $display("[TB] FAIL wake_alu got=%h exp=%h", dutVec(), expVec());
        end
        dispatch(OP_SUB, 32'h30, 32'd0, 1'b0, 4'd0, 1'b1, 4'd5, 4'd6);
        bus.lsb_cdb_flag_in = 1'b1; bus.lsb_cdb_idx_in = 4'd5; bus.lsb_cdb_val_in = 32'h22;
        tick();
        idle();
        tick();
        total++;
        if ({bus.alu_flag_out, bus.alu_op_out, bus.alu_val1_out, bus.alu_val2_out, bus.alu_idx_in_ROB_out}
            !== {1'b1, OP_SUB, 32'h30, 32'h22, 4'd6}) begin
            bad++; $display("[TB] FAIL wake_lsb_fwd got=%h exp=%h", dutVec(), expVec());
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < RS; i++) begin
            dispatch(OP_ADD, 32'd0, 32'(i + 100), 1'b1, 4'd9, 1'b0, 4'd0, 4'(i));
            tick();
        end
        total++;
        if (bus.full_out !== 1'b1 || dutVec() !== expVec()) begin
            bad++; $display("[TB] FAIL full_set got=%h exp=%h", dutVec(), expVec());
        end
        dispatch(OP_SUB, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
        tick();
        idle();
        bus.alu_cdb_flag_in = 1'b1; bus.alu_cdb_idx_in = 4'd9; bus.alu_cdb_val_in = 32'h99;
        tick();
        idle();
        for (int i = 0; i < RS; i++) begin
            tick();
            total++;
            if (bus.alu_flag_out !== 1'b1 || bus.alu_idx_in_ROB_out !== 4'(i) ||
                bus.alu_val1_out !== 32'h99 || bus.alu_val2_out !== 32'(i + 100) ||
                bus.full_out !== 1'b0) begin
                bad++; $display("[TB] FAIL full_drain_%0d got=%h exp=%h", i, dutVec(), expVec());
            end
        end
        tick();
        total++;
        if (bus.alu_flag_out !== 1'b0) begin
            bad++; $display("[TB] FAIL full_dropped got=%h exp=%h", dutVec(), expVec());
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 4; i++) begin
            dispatch(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd12, 1'b1, 4'd12, 4'(i));
            tick();
        end
        dispatch(OP_ADD, 32'd8, 32'd9, 1'b0, 4'd0, 1'b0, 4'd0, 4'd7);
        tick();
        dispatch(OP_SUB, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd8);
        bus.clear_in = 1'b1;
        tick();
        idle();
        total++;
        if (bus.alu_flag_out !== 1'b0 || bus.full_out !== 1'b0 || dutVec() !== expVec()) begin
            bad++; $display("[TB] FAIL clear_edge got=%h exp=%h", dutVec(), expVec());
        end
        bus.alu_cdb_flag_in = 1'b1; bus.alu_cdb_idx_in = 4'd12; bus.alu_cdb_val_in = 32'h77;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.alu_flag_out !== 1'b0) begin
                bad++; $display("[TB] FAIL clear_lost got=%h exp=%h", dutVec(), expVec());
            end
        end
    endtask

    task automatic test_rdy();
        for (int i = 0; i < 3; i++) begin
            dispatch(OP_ADD, 32'd0, 32'(i), 1'b1, 4'd7, 1'b0, 4'd0, 4'(i + 1));
            tick();
        end
        idle();
        bus.lsb_cdb_flag_in = 1'b1; bus.lsb_cdb_idx_in = 4'd7; bus.lsb_cdb_val_in = 32'hAB;
        tick();
        idle();
        bus.rdy = 1'b0;
        dispatch(OP_SUB, 32'd3, 32'd3, 1'b0, 4'd0, 1'b0, 4'd0, 4'd13);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.alu_flag_out !== 1'b0) begin
                bad++; $display("[TB] FAIL rdy_frozen got=%h exp=%h", dutVec(), expVec());
            end
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.alu_flag_out !== 1'b1 || bus.alu_idx_in_ROB_out !== 4'(i + 1) ||
                bus.alu_val1_out !== 32'hAB) begin
                bad++; $display("[TB] FAIL rdy_resume_%0d got=%h exp=%h", i, dutVec(), expVec());
            end
        end
        tick();
        total++;
        if (bus.alu_flag_out !== 1'b0) begin
            bad++; $display("[TB] FAIL rdy_dropped got=%h exp=%h", dutVec(), expVec());
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            bus.rdy = ($urandom_range(9) != 0);
            bus.clear_in = ($urandom_range(49) == 0);
            bus.issue_flag_in = !mFull() && ($urandom_range(9) < 6);
            bus.issue_op_in = 6'($urandom);
            bus.issue_Vj_in = $urandom; bus.issue_Vk_in = $urandom;
            bus.issue_Qj_busy_in = 1'($urandom_range(1)); bus.issue_Qj_in = 4'($urandom_range(3));
            bus.issue_Qk_busy_in = 1'($urandom_range(1)); bus.issue_Qk_in = 4'($urandom_range(3));
            bus.issue_idx_in_ROB_in = 4'($urandom);
            bus.alu_cdb_flag_in = ($urandom_range(2) == 0);
            bus.alu_cdb_idx_in = 4'($urandom_range(3)); bus.alu_cdb_val_in = $urandom;
            bus.lsb_cdb_flag_in = ($urandom_range(2) == 0);
            bus.lsb_cdb_idx_in = 4'($urandom_range(3)); bus.lsb_cdb_val_in = $urandom;
            if (bus.alu_cdb_flag_in && bus.lsb_cdb_flag_in && bus.alu_cdb_idx_in == bus.lsb_cdb_idx_in)
                bus.lsb_cdb_idx_in = bus.lsb_cdb_idx_in ^ 4'd1;
            tick();
            total++;
            if (dutVec() !== expVec()) begin
                bad++; $display("[TB] FAIL random_c%0d got=%h exp=%h", c, dutVec(), expVec());
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_basic();
        test_wakeup();
        test_full();
        test_clear();
        test_rdy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rs_alu.md
# rs_alu

Reservation station and issue scheduler for the integer ALU. It buffers up to `RS_SIZE` decoded ALU/branch/JALR micro-ops. It snoops the ALU and load/store result broadcasts to resolve operand tags. Each cycle it selects one ready entry, drives its opcode, operands and ROB index into the combinational ALU, and frees the entry. It sits between the decoder/dispatch stage and the ALU, and flushes on a ROB misprediction clear.

## Interface
- `RS_SIZE`, 8: number of entries; power of two, 2..16.
- `ROB_W`, 4: ROB index width; matches `ROB_INDEX_RANGE`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rdy` in 1: global ready; low freezes the block.
- `clear_in` in 1: ROB flush (mispredict); synchronous.
- `issue_flag_in` in 1: dispatch valid this cycle.
- `issue_op_in` in 6: ALU opcode (`ADD`…`JALR` encodings).
- `issue_Vj_in`, `issue_Vk_in` in 32: operand values, meaningful when the matching busy bit is 0.
- `issue_Qj_busy_in`, `issue_Qk_busy_in` in 1: operand waits on a tag.
- `issue_Qj_in`, `issue_Qk_in` in ROB_W: producer ROB index.
- `issue_idx_in_ROB_in` in ROB_W: destination ROB index.
- `alu_cdb_flag_in` in 1, `alu_cdb_idx_in` in ROB_W, `alu_cdb_val_in` in 32: ALU result broadcast.
- `lsb_cdb_flag_in` in 1, `lsb_cdb_idx_in` in ROB_W, `lsb_cdb_val_in` in 32: load result broadcast.
- `full_out` out 1: no free entry (combinational from state).
- `alu_flag_out` out 1: registered issue valid to the ALU.
- `alu_op_out` out 6: opcode of the issued entry.
- `alu_val1_out` out 32: first operand of the issued entry.
- `alu_val2_out` out 32: second operand of the issued entry.
- `alu_idx_in_ROB_out` out ROB_W: ROB index of the issued entry.

## Operation
- Entry fields: busy, op, Vj, Vk, Qj_busy, Qk_busy, Qj, Qk, rob_idx.
- An entry is ready when it is busy and both Q*_busy bits are 0.
- Reset (async): all busy=0. All outputs are 0: `full_out`=0, `alu_flag_out`=0, `alu_op_out`/`alu_val1_out`/`alu_val2_out`/`alu_idx_in_ROB_out`=0.
- Insert:
  - Condition: `issue_flag_in` & !`full_out` & !`clear_in` & `rdy`.
  - Target is the lowest-index non-busy entry.
  - Issue with `full_out`=1 is ignored; the decoder must not send it.
- Insert-time forwarding: an incoming busy tag that matches a same-cycle CDB broadcast stores that value with busy=0. The ALU CDB is checked before the LSB CDB, but both cannot carry the same index.
- Wakeup: every busy entry compares Qj/Qk against both CDBs each cycle. On a match it latches the value and clears the busy bit, so it is ready the next cycle.
- Select: the lowest-index ready entry, based on state before this edge's updates, is written to the output registers with `alu_flag_out`=1. That entry's busy bit clears on the same edge. If no entry is ready, `alu_flag_out`=0 and the data outputs hold their previous values.
- One entry may be inserted and a different one issued on the same edge. A just-inserted entry is never selected on its insert edge.
- `clear_in` (with `rdy`): all busy=0 and `alu_flag_out`=0 at the edge. It takes priority over insert, wakeup and select.
- `rdy`=0: all entries hold, and `alu_flag_out` registers 0 so the ALU does not rebroadcast.
- `full_out` = AND of all busy bits.

## Timing
- Minimum dispatch-to-ALU latency is 1 cycle: ready-at-dispatch at edge N gives `alu_flag_out` high after edge N+1.
- Wakeup latency: CDB at edge N gives the consumer eligible at edge N+1 and on the ALU after that edge.
- Throughput is one issue per cycle.
- `full_out` updates after the edge that fills or frees the last entry.

## Test plan
- Reset mid-operation with 3 busy entries → all outputs 0 immediately; `full_out`=0; no issue afterward.
- Dispatch ADD, Vj=5, Vk=7, no tags, ROB 3 → next cycle `alu_flag_out`=1, op=ADD, val1=5, val2=7, idx=3; then 0.
- Dispatch SUB with Qj busy on ROB 2; 2 cycles later `alu_cdb` idx=2, val=0x10 → issue on the following cycle with val1=0x10. Repeat with the tag matching an LSB broadcast in the dispatch cycle → issue the next cycle.
- Fill 8 entries all waiting on ROB 9 → `full_out`=1 and a 9th dispatch is dropped. Broadcast idx 9 → entries 0..7 issue in index order over 8 consecutive cycles; `full_out` drops after the first issue.
- `clear_in` while 4 entries are busy and one is being dispatched → `alu_flag_out`=0, all free, and the dispatched op is lost.
- `rdy`=0 for 3 cycles with ready entries → no issue and state held; issue resumes the cycle after `rdy`=1.
